// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block engine: FSM states, round
// constants, initial hash values and the FIPS 180-4 logical functions.
// The SHA-224 IV is only present when SHA256_ENGINE_SHA224_EN is defined.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUNDS,
    S_ADD,
    S_OUT
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // H0 occupies the top word, matching the digest port layout.
  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

`ifdef SHA256_ENGINE_SHA224_EN
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round. Chained by the engine to
// perform several rounds per clock.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] f_i,
  input  logic [31:0] g_i,
  input  logic [31:0] h_i,
  input  logic [31:0] w_i,
  input  logic [31:0] k_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o,
  output logic [31:0] f_o,
  output logic [31:0] g_o,
  output logic [31:0] h_o
);

  logic [31:0] t1, t2;

  assign t1  = h_i + bsig1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
  assign t2  = bsig0(a_i) + maj(a_i, b_i, c_i);

  assign a_o = t1 + t2;
  assign b_o = a_i;
  assign c_o = b_i;
  assign d_o = c_i;
  assign e_o = d_i + t1;
  assign f_o = e_i;
  assign g_o = f_i;
  assign h_o = g_i;

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: ROUNDS_PER_CYCLE rounds per clock over a
// rolling 16-word message window, with H held internally for multi-block
// chaining and valid/ready handshakes on word input and digest output.
// Optional SHA-224 support is compiled in with SHA256_ENGINE_SHA224_EN.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int DIGEST_W         = 256
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blk_start,
  input  logic                blk_first,
  input  logic                mode_224,
  input  logic [31:0]         word_data,
  input  logic                word_valid,
  output logic                word_ready,
  output logic                busy,
  output logic [DIGEST_W-1:0] digest,
  output logic                dig_valid,
  input  logic                dig_ready
);

  localparam int         R      = ROUNDS_PER_CYCLE;
  localparam logic [5:0] T_STEP = 6'(R);
  localparam logic [5:0] T_LAST = 6'(64 - R);

  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
    $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end
  if (DIGEST_W != 256) begin : g_bad_width
    $error("sha256_block_engine: DIGEST_W must be 256");
  end

  state_e            state_q, state_d;
  logic [7:0][31:0]  h_q, h_d;        // index i holds Hi
  logic [7:0][31:0]  work_q, work_d;  // index 0 = a ... 7 = h
  logic [15:0][31:0] win_q, win_d;    // slot 0 = oldest word
  logic [5:0]        t_q, t_d;
  logic [3:0]        ld_cnt_q, ld_cnt_d;
  logic              busy_q, busy_d;
  logic              dig_valid_q, dig_valid_d;
  logic [255:0]      digest_q, digest_d;
  logic [255:0]      iv_sel;
  logic [7:0][31:0]  h_sum;
  logic [7:0][31:0]  st_last;
  logic [15:0][31:0] win_last;

`ifdef SHA256_ENGINE_SHA224_EN
  logic mode_q, mode_d;
  assign iv_sel = mode_224 ? IV224 : IV256;
`else
  logic unused_mode;
  assign unused_mode = mode_224;
  assign iv_sel      = IV256;
`endif

  // Round chain: each stage does one round on window slot 0 and shifts the
  // freshly scheduled word into slot 15, so stage j sees original slot j.
  for (genvar j = 0; j < R; j++) begin : g_rnd
    logic [7:0][31:0]  st_i, st_o;
    logic [15:0][31:0] win_i, win_o;
    logic [31:0]       w_new;

    if (j == 0) begin : g_head
      assign st_i  = work_q;
      assign win_i = win_q;
    end else begin : g_link
      assign st_i  = g_rnd[j-1].st_o;
      assign win_i = g_rnd[j-1].win_o;
    end

    assign w_new = ssig1(win_i[14]) + win_i[9] + ssig0(win_i[1]) + win_i[0];
    assign win_o = {w_new, win_i[15:1]};

    sha256_round u_round (
      .a_i(st_i[0]), .b_i(st_i[1]), .c_i(st_i[2]), .d_i(st_i[3]),
      .e_i(st_i[4]), .f_i(st_i[5]), .g_i(st_i[6]), .h_i(st_i[7]),
      .w_i(win_i[0]),
      .k_i(K[t_q + 6'(j)]),
      .a_o(st_o[0]), .b_o(st_o[1]), .c_o(st_o[2]), .d_o(st_o[3]),
      .e_o(st_o[4]), .f_o(st_o[5]), .g_o(st_o[6]), .h_o(st_o[7])
    );
  end

  assign st_last  = g_rnd[R-1].st_o;
  assign win_last = g_rnd[R-1].win_o;

  // Feed-forward sum of the held H and the final working variables.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + work_q[i];
  end

  // Next-state and datapath control for the block FSM.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    work_d      = work_q;
    win_d       = win_q;
    t_d         = t_q;
    ld_cnt_d    = ld_cnt_q;
    busy_d      = busy_q;
    dig_valid_d = dig_valid_q;
    digest_d    = digest_q;
`ifdef SHA256_ENGINE_SHA224_EN
    mode_d      = mode_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (blk_start) begin
          state_d  = S_LOAD;
          busy_d   = 1'b1;
          ld_cnt_d = '0;
`ifdef SHA256_ENGINE_SHA224_EN
          mode_d   = mode_224;
`endif
          if (blk_first) begin
            for (int i = 0; i < 8; i++) h_d[i] = iv_sel[255-32*i -: 32];
          end
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          win_d    = {word_data, win_q[15:1]};
          ld_cnt_d = ld_cnt_q + 4'd1;
          if (ld_cnt_q == 4'd15) begin
            work_d  = h_q;
            t_d     = '0;
            state_d = S_ROUNDS;
          end
        end
      end
      S_ROUNDS: begin
        work_d = st_last;
        win_d  = win_last;
        t_d    = t_q + T_STEP;
        if (t_q == T_LAST) state_d = S_ADD;
      end
      S_ADD: begin
        h_d = h_sum;
        for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = h_sum[i];
`ifdef SHA256_ENGINE_SHA224_EN
        // H7 stays in h_q for chaining; only the output word is cleared.
        if (mode_q) digest_d[31:0] = '0;
`endif
        dig_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (dig_ready) begin
          dig_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any block in flight and clears H.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      work_q      <= '0;
      win_q       <= '0;
      t_q         <= '0;
      ld_cnt_q    <= '0;
      busy_q      <= 1'b0;
      dig_valid_q <= 1'b0;
      digest_q    <= '0;
`ifdef SHA256_ENGINE_SHA224_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      work_q      <= work_d;
      win_q       <= win_d;
      t_q         <= t_d;
      ld_cnt_q    <= ld_cnt_d;
      busy_q      <= busy_d;
      dig_valid_q <= dig_valid_d;
      digest_q    <= digest_d;
`ifdef SHA256_ENGINE_SHA224_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign word_ready = (state_q == S_LOAD);
  assign busy       = busy_q;
  assign dig_valid  = dig_valid_q;
  assign digest     = digest_q;

endmodule
